// File: rtl/niosii_system_button_pio_db.sv
`default_nettype none
// ============================================================================
// niosii_system_button_pio_db -- debounced WIDTH-channel button PIO with
// run-time edge select, W1C edge capture and level IRQ on Avalon-MM.
// Optional macro BUTTON_PIO_EVENT_COUNT_EN: capture-event counter at addr 5.
// Revision: 1.0
// ============================================================================
module niosii_system_button_pio_db #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] capture_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign edges        = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
  assign capture_clr  = (wr_en && address == 3'd3) ? wdata : '0;

  // Each channel restarts its count whenever the synchronised input agrees
  // with the accepted level, so any glitch shorter than the window is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= IDLE_VEC;
      sync      <= IDLE_VEC;
      stable    <= IDLE_VEC;
      stable_d  <= IDLE_VEC;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
      stable_d  <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A new edge in the same cycle as a W1C clear keeps its capture bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en      <= '0;
      fall_en      <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~capture_clr) | edges;
      irq          <= |(edge_capture & irq_mask);
      readdata     <= rd_mux;
      if (wr_en && address == 3'd1) rise_en  <= wdata;
      if (wr_en && address == 3'd2) irq_mask <= wdata;
      if (wr_en && address == 3'd4) fall_en  <= wdata;
    end
  end

`ifdef BUTTON_PIO_EVENT_COUNT_EN
  logic [7:0] event_count;
  logic       new_event;

  assign new_event = |(edges & ~edge_capture);

  always_ff @(posedge clk) begin
    if (reset) begin
      event_count <= 8'd0;
    end else if (wr_en && address == 3'd5) begin
      event_count <= new_event ? 8'd1 : 8'd0;
    end else if (new_event && event_count != 8'hFF) begin
      event_count <= event_count + 8'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux[WIDTH-1:0] = stable;
      3'd1: rd_mux[WIDTH-1:0] = rise_en;
      3'd2: rd_mux[WIDTH-1:0] = irq_mask;
      3'd3: rd_mux[WIDTH-1:0] = edge_capture;
      3'd4: rd_mux[WIDTH-1:0] = fall_en;
`ifdef BUTTON_PIO_EVENT_COUNT_EN
      3'd5: rd_mux[7:0] = event_count;
`endif
      default: rd_mux = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_niosii_system_button_pio_db.sv
`default_nettype none
// ============================================================================
// tb_niosii_system_button_pio_db -- directed scenarios plus randomized traffic
// against a history-based reference model (WIDTH=4, DEBOUNCE_CYCLES=4).
// Revision: 1.0
// ============================================================================
module tb_niosii_system_button_pio_db;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic [2:0]    address    = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'd0;
  logic [W-1:0]  in_port    = '1;
  logic [31:0]   readdata;
  logic          irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  niosii_system_button_pio_db #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Reference model: a level is accepted once the last D synchronised samples
  // all disagree with the currently accepted level.
  logic [W-1:0] m_s1, m_s2, m_stable, m_stable_d;
  logic [W-1:0] m_rise_en, m_fall_en, m_mask, m_cap;
  logic [W-1:0] m_hist [D];
  logic [31:0]  m_rd;
  logic         m_irq;
  int           m_evcnt;
  logic [W-1:0] t_ed, t_new, t_clr;
  logic [31:0]  t_rd;
  logic         t_wr, t_nw, t_all;

  function automatic logic [W-1:0] m_edges();
    return (m_stable & ~m_stable_d & m_rise_en) | (~m_stable & m_stable_d & m_fall_en);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1; m_stable_d = '1;
      m_rise_en = '0; m_fall_en = '0; m_mask = '0; m_cap = '0;
      for (int k = 0; k < D; k++) m_hist[k] = '1;
      m_rd = '0; m_irq = 1'b0; m_evcnt = 0;
    end else begin
      t_wr = chipselect && !write_n;
      t_ed = m_edges();
      case (address)
        3'd0: t_rd = 32'(m_stable);
        3'd1: t_rd = 32'(m_rise_en);
        3'd2: t_rd = 32'(m_mask);
        3'd3: t_rd = 32'(m_cap);
        3'd4: t_rd = 32'(m_fall_en);
`ifdef BUTTON_PIO_EVENT_COUNT_EN
        3'd5: t_rd = 32'(m_evcnt);
`endif
        default: t_rd = 32'd0;
      endcase
      m_rd  = t_rd;
      m_irq = |(m_cap & m_mask);
      t_nw  = |(t_ed & ~m_cap);
      if (t_wr && address == 3'd5) m_evcnt = t_nw ? 1 : 0;
      else if (t_nw && m_evcnt < 255) m_evcnt = m_evcnt + 1;
      t_clr = (t_wr && address == 3'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~t_clr) | t_ed;
      if (t_wr && address == 3'd1) m_rise_en = writedata[W-1:0];
      if (t_wr && address == 3'd2) m_mask    = writedata[W-1:0];
      if (t_wr && address == 3'd4) m_fall_en = writedata[W-1:0];
      for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s2;
      t_new = m_stable;
      for (int i = 0; i < W; i++) begin
        t_all = 1'b1;
        for (int k = 0; k < D; k++) if (m_hist[k][i] == m_stable[i]) t_all = 1'b0;
        if (t_all) t_new[i] = ~m_stable[i];
      end
      m_stable_d = m_stable;
      m_stable   = t_new;
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  end

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk);
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_rd [5] = '{32'hF, 32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b1; in_port = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    end
    for (int a = 0; a < 5; a++) begin
      do_read(3'(a), d);
      total++;
      if (d !== exp_rd[a]) begin
        bad++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_rd[a]);
      end
    end
  endtask

  task automatic test_debounce_reject();
    logic [31:0] d;
    do_write(3'd4, 32'hF);
    do_write(3'd2, 32'hF);
    @(negedge clk) in_port = 4'hE;
    idle(3);
    in_port = 4'hF;
    idle(10);
    do_read(3'd0, d);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL glitch_data: got %h expected %h", d, 32'hF); end
    do_read(3'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_capture: got %h expected 0", d); end
    @(negedge clk) in_port = 4'hE;
    // 2 sync + 4 debounce -> capture at edge 7, irq at edge 8
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      total++;
      if (irq !== (k >= 8)) begin bad++; $display("FAIL press_irq_cyc%0d: got %b expected %b", k, irq, k >= 8); end
    end
    do_read(3'd0, d);
    total++; if (d !== 32'hE) begin bad++; $display("FAIL press_data: got %h expected %h", d, 32'hE); end
    do_read(3'd3, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL press_capture: got %h expected 1", d); end
  endtask

  task automatic test_edge_mode();
    logic [31:0] d;
    @(negedge clk) in_port = 4'hF;
    idle(10);
    do_write(3'd3, 32'hF);
    do_write(3'd1, 32'h2);
    do_write(3'd4, 32'h0);
    @(negedge clk) in_port = 4'hD;
    idle(10);
    do_read(3'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_press: got %h expected 0", d); end
    @(negedge clk) in_port = 4'hF;
    idle(10);
    do_read(3'd3, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL edge_release: got %h expected 2", d); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0]  d;
    logic [W-1:0] pend;
    bit           hit;
    do_write(3'd3, 32'hF);
    do_write(3'd1, 32'h3);
    do_write(3'd4, 32'h3);
    @(negedge clk) in_port = 4'hC;
    idle(10);
    do_read(3'd3, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL w1c_setup: got %h expected 3", d); end
    @(negedge clk) in_port = 4'hD;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      pend = m_edges();
      if (pend[0]) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL w1c_edge_wait: got timeout expected key0 edge"); end
    chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    do_read(3'd3, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL w1c_collision: got %h expected 3", d); end
    do_write(3'd3, 32'h3);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold: got %b expected 1", irq); end
    @(posedge clk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop: got %b expected 0", irq); end
    do_read(3'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h expected 0", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    do_write(3'd1, 32'h0);
    do_write(3'd4, 32'h4);
    do_write(3'd2, 32'h0);
    do_write(3'd3, 32'hF);
    @(negedge clk) in_port = 4'hB;
    idle(10);
    do_read(3'd3, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL mask_capture: got %h expected 4", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_off_irq: got %b expected 0", irq); end
    do_write(3'd2, 32'h4);
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_on_irq: got %b expected 1", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_write(3'd4, 32'h5);
    @(negedge clk) in_port = 4'hA;
    idle(10);
    do_read(3'd3, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL rstmid_setup: got %h expected 5", d); end
    @(negedge clk) in_port = 4'hF;
    idle(10);
    @(negedge clk) in_port = 4'hB;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    do_read(3'd0, d);
    total++; if (d !== 32'hF) begin bad++; $display("FAIL rstmid_data: got %h expected F", d); end
    for (int a = 1; a < 5; a++) begin
      do_read(3'(a), d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_reg%0d: got %h expected 0", a, d); end
    end
    idle(8);
    do_read(3'd0, d);
    total++; if (d !== 32'hB) begin bad++; $display("FAIL rstmid_held: got %h expected B", d); end
    do_read(3'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_nocap: got %h expected 0", d); end
  endtask

  task automatic test_random();
    do_write(3'd1, 32'($urandom));
    do_write(3'd4, 32'($urandom));
    do_write(3'd2, 32'($urandom));
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++) if ($urandom_range(0, 7) == 0) in_port[i] = ~in_port[i];
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      @(posedge clk); #1;
      total++;
      if (readdata !== m_rd) begin bad++; $display("FAIL rand_readdata@%0d: got %h expected %h", n, readdata, m_rd); end
      total++;
      if (irq !== m_irq) begin bad++; $display("FAIL rand_irq@%0d: got %b expected %b", n, irq, m_irq); end
    end
    @(negedge clk) chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_event_count();
    logic [31:0] d;
    logic [31:0] exp_full;
`ifdef BUTTON_PIO_EVENT_COUNT_EN
    exp_full = 32'd255;
`else
    exp_full = 32'd0;
`endif
    @(negedge clk) in_port = 4'hF;
    idle(10);
    do_write(3'd1, 32'h1);
    do_write(3'd4, 32'h1);
    do_write(3'd3, 32'hF);
    do_write(3'd5, 32'h0);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk) in_port[0] = ~in_port[0];
      idle(8);
      do_write(3'd3, 32'h1);
    end
    do_read(3'd5, d);
    total++; if (d !== exp_full) begin bad++; $display("FAIL evcnt_sat: got %h expected %h", d, exp_full); end
    total++; if (d !== m_rd) begin bad++; $display("FAIL evcnt_model: got %h expected %h", d, m_rd); end
    do_write(3'd5, 32'h0);
    do_read(3'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL evcnt_clear: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_debounce_reject();
    test_edge_mode();
    test_w1c_collision();
    test_mask();
    test_reset_mid();
    test_random();
    test_event_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
